sc_regballshifter_jug1: RTL and testbench
=========================================

# sc_regballshifter_jug1

Ball-position generator for player 1's half of the playfield. Holds the one-hot ball position on an 8-bit bus and moves it one step per game tick. Bounces it at the half-field boundary and at the player-1 edge when the player returns it, and reports misses. Its output bus drives CC_SIDECOMPARATOR_JUG1, whose active-low edge flags come back as inputs, closing the loop.

## Interface
- REGBALLSHIFTER_DATAWIDTH, 8, width of the position bus. Only 8 is supported: edge codes are 8'b10000000 and 8'b00010000.
- SC_REGBALLSHIFTER_JUG1_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_REGBALLSHIFTER_JUG1_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_REGBALLSHIFTER_JUG1_tick_InHigh  in  1  one-cycle move-enable pulse from the game prescaler.
- SC_REGBALLSHIFTER_JUG1_serve_InLow  in  1  serve request, active low (debounced button).
- SC_REGBALLSHIFTER_JUG1_hit_InLow  in  1  player-1 paddle, active low (debounced button).
- SC_REGBALLSHIFTER_JUG1_izquierda_InLow  in  1  low when the bus equals 8'b10000000 (from the comparator).
- SC_REGBALLSHIFTER_JUG1_derecha_InLow  in  1  low when the bus equals 8'b00010000 (from the comparator).
- SC_REGBALLSHIFTER_JUG1_data_OutBUS  out  8  one-hot ball position, registered.
- SC_REGBALLSHIFTER_JUG1_direction_Out  out  1  0 = moving/serving right (toward bit 4), 1 = moving left (toward bit 7).
- SC_REGBALLSHIFTER_JUG1_miss_OutLow  out  1  one-cycle active-low miss pulse, registered.
- SC_REGBALLSHIFTER_JUG1_misscount_OutBUS  out  4  saturating miss counter.

## Operation
- **Reset values:** state IDLE, data 8'b10000000, direction 0, miss_OutLow 1, misscount 0, hit_pending 0.
- **FSM states:** IDLE, RIGHT, LEFT, MISS.
- **IDLE**
  - data is held at 8'b10000000 and ticks are ignored.
  - serve_InLow = 0 moves to RIGHT next cycle; data is unchanged on that edge.
- **RIGHT**
  - On a tick with derecha_InLow = 1: data shifts right by 1 (logical, MSB filled 0).
  - On a tick with derecha_InLow = 0: no shift, go to LEFT, direction becomes 1 (boundary bounce).
  - Without a tick, nothing changes.
- **LEFT**
  - On a tick with izquierda_InLow = 1: data shifts left by 1 (LSB filled 0).
  - hit_pending is set on any cycle with izquierda_InLow = 0 and hit_InLow = 0. Presses while the ball is not at bit 7 are ignored.
  - On a tick with izquierda_InLow = 0:
    - If hit_pending = 1 (or hit_InLow = 0 in that same cycle): data shifts right to 8'b01000000, go to RIGHT, direction 0, hit_pending cleared.
    - Otherwise: go to MISS, data is held.
- **MISS** (lasts exactly one cycle)
  - miss_OutLow = 0 during it.
  - misscount increments, saturating at 4'hF.
  - Then go to IDLE with data 8'b10000000, direction 0, hit_pending 0.
- hit_pending is cleared on every tick and on every entry to IDLE.
- **Illegal-state guard:** if data is not one-hot, the next edge forces IDLE with data 8'b10000000.

## Timing
- All outputs are registered.
- Edge flags are combinational from data_OutBUS, so they are valid in the same cycle as the bus value they describe.
- Latency: tick at edge n produces the new position after edge n.
- Serve → first movement needs a later tick; the minimum is serve at edge n, movement at edge n+1.
- Simultaneous serve and tick in IDLE: serve wins and no shift occurs.
- serve_InLow outside IDLE is ignored.
- Hit and tick in the same cycle at bit 7 counts as a return.
- Asynchronous reset at any point (including MISS) immediately forces the reset values.
- misscount is not cleared by serve; only reset clears it.
- Right travel 7→4 takes 3 ticks; the bounce consumes 1 tick; left travel 4→7 takes 3 ticks.

## Test plan
- **Reset and serve:** reset asserted mid-RIGHT with data 8'b00100000 → data 8'b10000000, miss_OutLow 1, misscount 0 immediately. Then serve low, then 3 ticks → data 8'b00010000, derecha flag 0.
- **Boundary bounce:** continue the previous scenario with 4 more ticks → 8'b00010000 (no shift, direction 1), 8'b00100000, 8'b01000000, 8'b10000000.
- **Return:** ball at 8'b10000000 in LEFT, hit_InLow low 2 cycles before the tick → after the tick data 8'b01000000, direction 0.
- **Miss:** ball at bit 7 in LEFT, no hit, tick → one cycle with miss_OutLow 0, misscount 1, then IDLE with data 8'b10000000. An early hit press while the ball is at 8'b01000000 must not count.
- **Saturation:** 16 consecutive misses → misscount stays 4'hF, and the miss pulse still fires each time.
- **Serve-vs-tick collision:** serve low and tick high in the same IDLE cycle → state RIGHT, data stays 8'b10000000.

Source files
------------

// File: rtl/sc_regballshifter_jug1.sv
// rtl/sc_regballshifter_jug1.sv - player-1 one-hot ball position shifter with bounce, return and miss counting
module sc_regballshifter_jug1 #(
    parameter int REGBALLSHIFTER_DATAWIDTH = 8
) (
    input  logic                                SC_REGBALLSHIFTER_JUG1_CLOCK_50,
    input  logic                                SC_REGBALLSHIFTER_JUG1_RESET_InHigh,
    input  logic                                SC_REGBALLSHIFTER_JUG1_tick_InHigh,
    input  logic                                SC_REGBALLSHIFTER_JUG1_serve_InLow,
    input  logic                                SC_REGBALLSHIFTER_JUG1_hit_InLow,
    input  logic                                SC_REGBALLSHIFTER_JUG1_izquierda_InLow,
    input  logic                                SC_REGBALLSHIFTER_JUG1_derecha_InLow,
    output logic [REGBALLSHIFTER_DATAWIDTH-1:0] SC_REGBALLSHIFTER_JUG1_data_OutBUS,
    output logic                                SC_REGBALLSHIFTER_JUG1_direction_Out,
    output logic                                SC_REGBALLSHIFTER_JUG1_miss_OutLow,
    output logic [3:0]                          SC_REGBALLSHIFTER_JUG1_misscount_OutBUS
);

    // Ball parks at the player-1 edge (bit 7) between rallies.
    localparam logic [REGBALLSHIFTER_DATAWIDTH-1:0] leftEdge =
        REGBALLSHIFTER_DATAWIDTH'(8'b10000000);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2,
        MISS  = 2'd3
    } state_t;

    state_t                              state;
    logic [REGBALLSHIFTER_DATAWIDTH-1:0] ballPos;
    logic                                direction;
    logic                                missLow;
    logic [3:0]                          missCount;
    logic                                hitPending;

    logic tick;
    logic serveReq;
    logic hitReq;
    logic atLeftEdge;
    logic atRightEdge;

    assign tick        = SC_REGBALLSHIFTER_JUG1_tick_InHigh;
    assign serveReq    = ~SC_REGBALLSHIFTER_JUG1_serve_InLow;
    assign hitReq      = ~SC_REGBALLSHIFTER_JUG1_hit_InLow;
    assign atLeftEdge  = ~SC_REGBALLSHIFTER_JUG1_izquierda_InLow;
    assign atRightEdge = ~SC_REGBALLSHIFTER_JUG1_derecha_InLow;

    assign SC_REGBALLSHIFTER_JUG1_data_OutBUS      = ballPos;
    assign SC_REGBALLSHIFTER_JUG1_direction_Out    = direction;
    assign SC_REGBALLSHIFTER_JUG1_miss_OutLow      = missLow;
    assign SC_REGBALLSHIFTER_JUG1_misscount_OutBUS = missCount;

    // Rally FSM: serve, travel to the half-field boundary, bounce back, return or miss at the player edge.
    always_ff @(posedge SC_REGBALLSHIFTER_JUG1_CLOCK_50 or posedge SC_REGBALLSHIFTER_JUG1_RESET_InHigh) begin
        if (SC_REGBALLSHIFTER_JUG1_RESET_InHigh) begin
            state      <= IDLE;
            ballPos    <= leftEdge;
            direction  <= 1'b0;
            missLow    <= 1'b1;
            missCount  <= 4'd0;
            hitPending <= 1'b0;
        end else begin
            // The miss pulse is a single cycle; it is only pulled low on the edge entering MISS.
            missLow <= 1'b1;
            if (!$onehot(ballPos)) begin
                // A corrupted position can never recover by shifting, so restart the rally.
                state      <= IDLE;
                ballPos    <= leftEdge;
                direction  <= 1'b0;
                hitPending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ballPos    <= leftEdge;
                        direction  <= 1'b0;
                        hitPending <= 1'b0;
                        if (serveReq) begin
                            state <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (tick) begin
                            hitPending <= 1'b0;
                            if (!atRightEdge) begin
                                ballPos <= ballPos >> 1;
                            end else begin
                                // The bounce itself uses up this tick; the ball does not move.
                                state     <= LEFT;
                                direction <= 1'b1;
                            end
                        end
                    end
                    LEFT: begin
                        if (tick) begin
                            hitPending <= 1'b0;
                            if (!atLeftEdge) begin
                                ballPos <= ballPos << 1;
                            end else if (hitPending || hitReq) begin
                                ballPos   <= ballPos >> 1;
                                state     <= RIGHT;
                                direction <= 1'b0;
                            end else begin
                                state   <= MISS;
                                missLow <= 1'b0;
                                if (missCount != 4'hF) begin
                                    missCount <= missCount + 4'd1;
                                end
                            end
                        end else if (atLeftEdge && hitReq) begin
                            // Remember an early press made while the ball waits at the edge.
                            hitPending <= 1'b1;
                        end
                    end
                    MISS: begin
                        state      <= IDLE;
                        ballPos    <= leftEdge;
                        direction  <= 1'b0;
                        hitPending <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        ballPos    <= leftEdge;
                        direction  <= 1'b0;
                        hitPending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sc_regballshifter_jug1.sv
// tb/tb_sc_regballshifter_jug1.sv - table-driven scoreboard bench for sc_regballshifter_jug1
module tb_sc_regballshifter_jug1;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       serveN;
    logic       hitN;
    logic       izqN;
    logic       derN;
    logic [7:0] data;
    logic       dir;
    logic       missN;
    logic [3:0] cnt;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic       serve;
        logic       hit;
        logic       tick;
        logic [7:0] eData;
        logic       eDir;
        logic       eMiss;
        logic [3:0] eCnt;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       dir;
        logic       miss;
        logic [3:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    sc_regballshifter_jug1 #(.REGBALLSHIFTER_DATAWIDTH(8)) dut (
        .SC_REGBALLSHIFTER_JUG1_CLOCK_50        (clk),
        .SC_REGBALLSHIFTER_JUG1_RESET_InHigh    (rst),
        .SC_REGBALLSHIFTER_JUG1_tick_InHigh     (tick),
        .SC_REGBALLSHIFTER_JUG1_serve_InLow     (serveN),
        .SC_REGBALLSHIFTER_JUG1_hit_InLow       (hitN),
        .SC_REGBALLSHIFTER_JUG1_izquierda_InLow (izqN),
        .SC_REGBALLSHIFTER_JUG1_derecha_InLow   (derN),
        .SC_REGBALLSHIFTER_JUG1_data_OutBUS     (data),
        .SC_REGBALLSHIFTER_JUG1_direction_Out   (dir),
        .SC_REGBALLSHIFTER_JUG1_miss_OutLow     (missN),
        .SC_REGBALLSHIFTER_JUG1_misscount_OutBUS(cnt)
    );

    // Side comparator closing the loop
    assign izqN = (data != 8'b10000000);
    assign derN = (data != 8'b00010000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t v(input logic s, input logic h, input logic t,
                               input logic [7:0] d, input logic dr, input logic m,
                               input logic [3:0] c);
        vec_t r;
        r.serve = s; r.hit = h; r.tick = t;
        r.eData = d; r.eDir = dr; r.eMiss = m; r.eCnt = c;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic h, input logic t,
                        input logic [7:0] ed, input logic edir, input logic em,
                        input logic [3:0] ec, input string nm);
        exp_t e;
        serveN = s; hitN = h; tick = t;
        e.d = ed; e.dir = edir; e.miss = em; e.cnt = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, " data"}, 32'(data), 32'(e.d));
            chk({nm, " dir"},  32'(dir),  32'(e.dir));
            chk({nm, " miss"}, 32'(missN), 32'(e.miss));
            chk({nm, " cnt"},  32'(cnt),  32'(e.cnt));
        end
        serveN = 1'b1; hitN = 1'b1; tick = 1'b0;
    endtask

    // From IDLE: serve, travel 7->4, bounce, travel 4->7; ends in LEFT at bit 7
    task automatic runToLeftEdge(input logic [3:0] c, input string nm);
        step(1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, c, {nm, " serve"});
        step(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1, c, {nm, " r1"});
        step(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, c, {nm, " r2"});
        step(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, c, {nm, " r3"});
        chk({nm, " derecha flag"}, 32'(derN), 32'd0);
        step(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, c, {nm, " bounce"});
        step(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, c, {nm, " l1"});
        step(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b1, c, {nm, " l2"});
        step(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, c, {nm, " l3"});
        chk({nm, " izquierda flag"}, 32'(izqN), 32'd0);
    endtask

    task automatic asyncResetCheck(input string nm);
        rst = 1'b1;
        #1;
        chk({nm, " data"}, 32'(data),  32'h80);
        chk({nm, " dir"},  32'(dir),   32'd0);
        chk({nm, " miss"}, 32'(missN), 32'd1);
        chk({nm, " cnt"},  32'(cnt),   32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] c;
        rst = 1'b0; tick = 1'b0; serveN = 1'b1; hitN = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset data", 32'(data),  32'h80);
        chk("reset dir",  32'(dir),   32'd0);
        chk("reset miss", 32'(missN), 32'd1);
        chk("reset cnt",  32'(cnt),   32'd0);

        //               serve hit  tick  data   dir   miss  cnt
        tbl.push_back(v(1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 4'd0)); // serve
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 4'd0)); // bounce
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 4'd0)); // early hit
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 4'd0)); // return
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1, 4'd0)); // press off-edge
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h40, 1'b1, 1'b1, 4'd0)); // press off-edge
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 4'd0));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 4'd1)); // miss
        tbl.push_back(v(1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 4'd1)); // back to idle
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 4'd1)); // tick ignored in idle
        tbl.push_back(v(1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 4'd1)); // serve+tick collision
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 4'd1));
        tbl.push_back(v(1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 4'd1)); // serve outside idle
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 4'd1));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 4'd1));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 4'd1));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 4'd1));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 4'd1));
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 4'd1));
        tbl.push_back(v(1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 4'd1)); // hit+tick same cycle
        tbl.push_back(v(1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 4'd1));

        foreach (tbl[i]) begin
            step(tbl[i].serve, tbl[i].hit, tbl[i].tick,
                 tbl[i].eData, tbl[i].eDir, tbl[i].eMiss, tbl[i].eCnt,
                 $sformatf("row%0d", i));
        end

        // Mid-RIGHT at 8'b00100000: asynchronous reset acts immediately
        asyncResetCheck("reset midright");

        // First miss after reset, then saturation over 16 more misses
        for (int k = 1; k <= 17; k++) begin
            c = (k - 1 > 15) ? 4'hF : 4'(k - 1);
            runToLeftEdge(c, $sformatf("rally%0d", k));
            c = (k > 15) ? 4'hF : 4'(k);
            step(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, c, $sformatf("miss%0d", k));
            step(1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, c, $sformatf("idle%0d", k));
        end

        // Reset while in MISS
        runToLeftEdge(4'hF, "final rally");
        step(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 4'hF, "final miss");
        asyncResetCheck("reset inmiss");
        step(1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 4'd0, "post reset idle");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
